// File: rtl/pipeline_stall_controller_pkg.sv
// pipeline_stall_controller_pkg: shared FSM states, default sizes and stage-control bundle
package pipeline_stall_controller_pkg;
  typedef enum logic [0:0] {RUN = 1'b0, MEM_WAIT = 1'b1} state_e;
  localparam int DEF_MEM_TIMEOUT = 64;
  localparam int DEF_STAT_W = 16;
  typedef struct packed {
    logic freeze_pc;
    logic freeze_ifid;
    logic bubble_idexe;
    logic flush_if;
    logic flush_id;
    logic freeze_back;
  } stage_ctrl_t;
endpackage

// File: rtl/pipeline_stall_controller_sat_counter.sv
// pipeline_stall_controller_sat_counter: saturating event counter with async active-low clear
module pipeline_stall_controller_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);
  logic [W-1:0] count_q, count_d;
  // hold at all-ones instead of wrapping
  always_comb count_d = (inc && count_q != '1) ? count_q + 1'b1 : count_q;
  // count register
  always_ff @(posedge clk or negedge rst)
    if (!rst) count_q <= '0;
    else count_q <= count_d;
  assign count = count_q;
endmodule

// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller: stall/flush sequencer and SRAM handshake owner; PIPELINE_STALL_STATS_EN builds statistics counters
module pipeline_stall_controller
  import pipeline_stall_controller_pkg::*;
#(
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
  parameter int STAT_W = DEF_STAT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hazardDetected,
  input  logic              branchTaken,
  input  logic              memReadMEM,
  input  logic              memWriteMEM,
  input  logic              sramReady,
  output logic              sramStart,
  output logic              freezePC,
  output logic              freezeIFID,
  output logic              bubbleIDEXE,
  output logic              flushIF,
  output logic              flushID,
  output logic              freezeBack,
  output logic              memTimeout,
  output logic [STAT_W-1:0] hazardStallCount,
  output logic [STAT_W-1:0] memStallCount,
  output logic [STAT_W-1:0] flushCount
);
  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [0:0] ST_RUN = RUN;
  localparam logic [0:0] ST_WAIT = MEM_WAIT;
  logic [0:0] state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic mem_timeout_q, mem_timeout_d;
  logic sram_start;
  stage_ctrl_t ctrl;
  logic mem_req;
  assign mem_req = memReadMEM | memWriteMEM;
  // priority: memory access, then branch flush, then hazard stall; MEM_WAIT freezes until ready or timeout
  always_comb begin
    ctrl = '0;
    sram_start = 1'b0;
    state_d = state_q;
    cnt_d = cnt_q;
    mem_timeout_d = mem_timeout_q;
    if (state_q == ST_RUN) begin
      if (mem_req) begin
        sram_start = 1'b1;
        ctrl.freeze_pc = 1'b1;
        ctrl.freeze_ifid = 1'b1;
        ctrl.freeze_back = 1'b1;
        state_d = ST_WAIT;
        cnt_d = '0;
      end else if (branchTaken) begin
        ctrl.flush_if = 1'b1;
        ctrl.flush_id = 1'b1;
      end else if (hazardDetected) begin
        ctrl.freeze_pc = 1'b1;
        ctrl.freeze_ifid = 1'b1;
        ctrl.bubble_idexe = 1'b1;
      end
    end else if (sramReady || cnt_q == CNT_MAX) begin
      state_d = ST_RUN;
    end else begin
      ctrl.freeze_pc = 1'b1;
      ctrl.freeze_ifid = 1'b1;
      ctrl.freeze_back = 1'b1;
      cnt_d = cnt_q + 1'b1;
      mem_timeout_d = mem_timeout_q | (cnt_q == CNT_PRE);
    end
  end
  // state, wait counter and sticky timeout flag
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= ST_RUN;
      cnt_q <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  assign {freezePC, freezeIFID, bubbleIDEXE, flushIF, flushID, freezeBack} = rst ? ctrl : '0;
  assign sramStart = rst & sram_start;
  assign memTimeout = rst & mem_timeout_q;
`ifdef PIPELINE_STALL_STATS_EN
  pipeline_stall_controller_sat_counter #(.W(STAT_W)) u_hazard_cnt (
    .clk(clk), .rst(rst), .inc(bubbleIDEXE), .count(hazardStallCount)
  );
  pipeline_stall_controller_sat_counter #(.W(STAT_W)) u_mem_cnt (
    .clk(clk), .rst(rst), .inc(freezeBack), .count(memStallCount)
  );
  pipeline_stall_controller_sat_counter #(.W(STAT_W)) u_flush_cnt (
    .clk(clk), .rst(rst), .inc(flushIF), .count(flushCount)
  );
`else
  assign hazardStallCount = '0;
  assign memStallCount = '0;
  assign flushCount = '0;
`endif
endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb_pipeline_stall_controller: directed plus random stimulus against a cycle-level behavioural model
module tb_pipeline_stall_controller;
  localparam int T = 8;
  localparam int SW = 4;
  localparam int SMAX = (1 << SW) - 1;
  logic clk = 1'b0;
  logic rst, hazardDetected, branchTaken, memReadMEM, memWriteMEM, sramReady;
  logic sramStart, freezePC, freezeIFID, bubbleIDEXE, flushIF, flushID, freezeBack, memTimeout;
  logic [SW-1:0] hazardStallCount, memStallCount, flushCount;
  int checks = 0, errors = 0;
  int m_wait, m_k, m_to, m_hz, m_ms, m_fl;
  int n_fb, n_st, n_bub;
  pipeline_stall_controller #(.MEM_TIMEOUT(T), .STAT_W(SW)) dut (
    .clk(clk), .rst(rst), .hazardDetected(hazardDetected), .branchTaken(branchTaken),
    .memReadMEM(memReadMEM), .memWriteMEM(memWriteMEM), .sramReady(sramReady),
    .sramStart(sramStart), .freezePC(freezePC), .freezeIFID(freezeIFID),
    .bubbleIDEXE(bubbleIDEXE), .flushIF(flushIF), .flushID(flushID),
    .freezeBack(freezeBack), .memTimeout(memTimeout),
    .hazardStallCount(hazardStallCount), .memStallCount(memStallCount), .flushCount(flushCount)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int sat(input int v);
    return v > SMAX ? SMAX : v;
  endfunction
  task automatic step(input logic r, mr, mw, br, hz, rdy);
    int e_st, e_fpc, e_bub, e_fl, e_fb, rel;
    @(negedge clk);
    rst = r; memReadMEM = mr; memWriteMEM = mw; branchTaken = br; hazardDetected = hz; sramReady = rdy;
    #2;
    if (!r) begin
      m_wait = 0; m_k = 0; m_to = 0; m_hz = 0; m_ms = 0; m_fl = 0;
    end
    e_st = 0; e_fpc = 0; e_bub = 0; e_fl = 0; e_fb = 0;
    rel = m_wait && (rdy || m_k > T);
    if (r) begin
      if (!m_wait) begin
        if (mr || mw) begin e_st = 1; e_fpc = 1; e_fb = 1; end
        else if (br) e_fl = 1;
        else if (hz) begin e_fpc = 1; e_bub = 1; end
      end else if (!rel) begin
        e_fpc = 1; e_fb = 1;
      end
    end
    check("sramStart", 32'(sramStart), 32'(e_st));
    check("freezePC", 32'(freezePC), 32'(e_fpc));
    check("freezeIFID", 32'(freezeIFID), 32'(e_fpc));
    check("bubbleIDEXE", 32'(bubbleIDEXE), 32'(e_bub));
    check("flushIF", 32'(flushIF), 32'(e_fl));
    check("flushID", 32'(flushID), 32'(e_fl));
    check("freezeBack", 32'(freezeBack), 32'(e_fb));
    check("memTimeout", 32'(memTimeout), 32'(m_to));
`ifdef PIPELINE_STALL_STATS_EN
    check("hazardStallCount", 32'(hazardStallCount), 32'(m_hz));
    check("memStallCount", 32'(memStallCount), 32'(m_ms));
    check("flushCount", 32'(flushCount), 32'(m_fl));
`else
    check("hazardStallCount", 32'(hazardStallCount), 0);
    check("memStallCount", 32'(memStallCount), 0);
    check("flushCount", 32'(flushCount), 0);
`endif
    n_fb += int'(freezeBack); n_st += int'(sramStart); n_bub += int'(bubbleIDEXE);
    if (r) begin
      m_hz = sat(m_hz + e_bub); m_ms = sat(m_ms + e_fb); m_fl = sat(m_fl + e_fl);
      if (!m_wait) begin
        if (mr || mw) begin m_wait = 1; m_k = 1; end
      end else if (rel) m_wait = 0;
      else begin
        if (m_k == T) m_to = 1;
        m_k++;
      end
    end
  endtask
  initial begin
    rst = 1'b0; hazardDetected = 0; branchTaken = 0; memReadMEM = 0; memWriteMEM = 0; sramReady = 0;
    m_wait = 0; m_k = 0; m_to = 0; m_hz = 0; m_ms = 0; m_fl = 0;
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 1, 0);
    step(1, 0, 0, 0, 0, 1);
    n_bub = 0;
    step(1, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0);
    check("hazard_bubble_cycles", 32'(n_bub), 2);
    n_fb = 0; n_st = 0;
    step(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 1);
    check("memwait_freezeBack_cycles", 32'(n_fb), 4);
    check("memwait_sramStart_cycles", 32'(n_st), 1);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 1, 0);
    step(1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 2; i++) step(1, 0, 1, 1, 0, 0);
    step(1, 0, 1, 1, 0, 1);
    step(1, 0, 0, 1, 0, 0);
    n_fb = 0;
    step(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < T + 1; i++) step(1, 1, 0, 0, 0, 0);
    check("timeout_freezeBack_cycles", 32'(n_fb), T + 1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    n_st = 0;
    step(1, 1, 0, 0, 0, 0);
    check("post_reset_sramStart", 32'(n_st), 1);
    for (int i = 0; i < 3000; i++) begin
      logic r, mr, mw, br, hz, rdy;
      r = $urandom_range(99) != 0;
      mr = m_wait ? 1'b1 : $urandom_range(3) == 0;
      mw = $urandom_range(5) == 0;
      br = $urandom_range(3) == 0;
      hz = $urandom_range(2) == 0;
      rdy = $urandom_range(7) == 0;
      step(r, mr, mw, br, hz, rdy);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
